// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit-count helper for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W    = 4;
  localparam int BCD_ADJ_THRESH = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  // Decimal digits needed for the largest unsigned value of the given width, i.e. ceil(width*log10(2)).
  function automatic int bcd_digits_needed(input int width);
    longint unsigned v;
    int n;
    v = (64'd1 << width) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: adds 3 to a BCD digit that is 5 or more, so the next shift carries correctly.
// Purely combinational, no handshake.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  always_comb begin
    adj = digit;
    if (digit >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) begin
      adj = digit + BCD_DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, optional sign/magnitude input.
// Result BIN_W+1 cycles after start is accepted; start is ignored while busy, accepted again in the DONE cycle.
module seq_bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          busy,
  output logic                          done,
  output logic                          sign_out,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  if ((BIN_W < 2) || (BIN_W > 32)) begin : g_bad_width
    $error("seq_bin_to_bcd: BIN_W=%0d is outside 2..32", BIN_W);
  end

  if (DIGITS < bcd_digits_needed(BIN_W)) begin : g_bad_digits
    $error("seq_bin_to_bcd: DIGITS=%0d too small for BIN_W=%0d (need %0d)",
           DIGITS, BIN_W, bcd_digits_needed(BIN_W));
  end

  bcd_state_t       state_q, state_d;
  logic [BIN_W-1:0] mag_q;
  logic [BCD_W-1:0] scr_q;
  logic [BCD_W-1:0] scr_adj;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;

  logic             load;
  logic             shift_en;
  logic             publish;
  logic             load_neg;
  logic [BIN_W-1:0] load_mag;

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit (scr_q[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adj   (scr_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Magnitude stays in BIN_W unsigned bits so the most negative input maps to 2^(BIN_W-1) cleanly.
  always_comb begin
    load_neg = (SIGNED != 0) && bin_in[BIN_W-1];
    load_mag = bin_in;
    if (load_neg) begin
      load_mag = ~bin_in + BIN_W'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    publish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        publish = 1'b1;
        if (start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      scr_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sign_out <= 1'b0;
      bcd_out  <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d == SHIFT);
      done    <= publish;
      // Publish reads the scratch before a back-to-back load overwrites it on the same edge.
      if (publish) begin
        bcd_out  <= scr_q;
        sign_out <= sign_q;
      end
      if (load) begin
        mag_q  <= load_mag;
        sign_q <= load_neg;
        scr_q  <= '0;
        cnt_q  <= CNT_W'(BIN_W);
      end else if (shift_en) begin
        scr_q <= {scr_adj[BCD_W-2:0], mag_q[BIN_W-1]};
        mag_q <= {mag_q[BIN_W-2:0], 1'b0};
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // With enough digits the top digit is at most 4 before any shift, so nothing is lost off the top.
  top_digit_no_carry: assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == SHIFT) |-> !scr_adj[BCD_W-1]
  );

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Scoreboard bench for seq_bin_to_bcd: 16-bit unsigned, 16-bit signed and 8-bit signed instances driven together.
module tb_seq_bin_to_bcd;

  typedef struct {
    logic [19:0] bcd;
    logic        sign;
    int          cyc;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bin   = '0;

  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  sign_v;
  logic [19:0] bcd_u;
  logic [19:0] bcd_s;
  logic [11:0] bcd_b;

  int          cycle = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  exp_t        sb [3][$];
  logic [19:0] held_bcd [3];
  logic        held_sign [3];
  logic        prev_done [3];
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin),
    .busy(busy_v[0]), .done(done_v[0]), .sign_out(sign_v[0]), .bcd_out(bcd_u)
  );

  seq_bin_to_bcd #(.BIN_W(16), .DIGITS(5), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin),
    .busy(busy_v[1]), .done(done_v[1]), .sign_out(sign_v[1]), .bcd_out(bcd_s)
  );

  seq_bin_to_bcd #(.BIN_W(8), .DIGITS(3), .SIGNED(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin[7:0]),
    .busy(busy_v[2]), .done(done_v[2]), .sign_out(sign_v[2]), .bcd_out(bcd_b)
  );

  task automatic chk_eq(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @cycle %0d: got %0h want %0h", tag, idx, cycle, got, exp);
    end
  endtask

  function automatic int width_of(input int i);
    return (i == 2) ? 8 : 16;
  endfunction

  function automatic logic [19:0] bcd_of(input int i);
    case (i)
      0:       return bcd_u;
      1:       return bcd_s;
      default: return {8'h00, bcd_b};
    endcase
  endfunction

  // Reference: decimal digits by repeated division, sign/magnitude from the instance's configuration.
  function automatic exp_t model(input int i, input logic [15:0] v);
    exp_t e;
    int   m;
    logic neg;
    if (i == 2) begin
      neg = v[7];
      m   = neg ? (256 - int'(v[7:0])) : int'(v[7:0]);
    end else if (i == 1) begin
      neg = v[15];
      m   = neg ? (65536 - int'(v)) : int'(v);
    end else begin
      neg = 1'b0;
      m   = int'(v);
    end
    e.bcd  = '0;
    e.sign = neg;
    e.cyc  = 0;
    for (int d = 0; d < 5; d++) begin
      e.bcd[d*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return e;
  endfunction

  // Drive start for one edge from the current negedge; every instance is idle so all accept.
  task automatic send(input logic [15:0] v);
    exp_t e;
    start = 1'b1;
    bin   = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e     = model(i, v);
      e.cyc = cycle;
      sb[i].push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_v != 3'b000) && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      chk_eq("idle_timeout", 0, 32'(busy_v), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      for (int i = 0; i < 3; i++) begin
        if (done_v[i]) begin
          chk_eq("done_width", i, 32'(prev_done[i]), 32'd0);
          if (sb[i].size() == 0) begin
            chk_eq("spurious_done", i, 32'(done_v[i]), 32'd0);
          end else begin
            mon_e = sb[i].pop_front();
            chk_eq("bcd", i, 32'(bcd_of(i)), 32'(mon_e.bcd));
            chk_eq("sign", i, 32'(sign_v[i]), 32'(mon_e.sign));
            chk_eq("latency", i, 32'(cycle - mon_e.cyc), 32'(width_of(i) + 1));
            held_bcd[i]  = mon_e.bcd;
            held_sign[i] = mon_e.sign;
          end
        end else begin
          chk_eq("hold_bcd", i, 32'(bcd_of(i)), 32'(held_bcd[i]));
          chk_eq("hold_sign", i, 32'(sign_v[i]), 32'(held_sign[i]));
        end
        prev_done[i] = done_v[i];
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk_eq({tag, "_busy"}, i, 32'(busy_v[i]), 32'd0);
      chk_eq({tag, "_done"}, i, 32'(done_v[i]), 32'd0);
      chk_eq({tag, "_sign"}, i, 32'(sign_v[i]), 32'd0);
      chk_eq({tag, "_bcd"}, i, 32'(bcd_of(i)), 32'd0);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      held_bcd[i]  = '0;
      held_sign[i] = 1'b0;
      prev_done[i] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] vecs [8];
    vecs = '{16'hFFFF, 16'd0, 16'd9, 16'd128, 16'd9999, 16'h8000, 16'hFFFF, 16'h7FFF};

    clear_model();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Single conversions, each launched as soon as all instances go idle.
    foreach (vecs[k]) begin
      send(vecs[k]);
      wait_idle();
    end
    send(16'h0080);
    wait_idle();

    // A second start while busy must be ignored; the operand is not re-captured.
    repeat (3) @(negedge clk);
    send(16'd123);
    repeat (4) @(negedge clk);
    start = 1'b1;
    bin   = 16'd999;
    @(posedge clk);
    #1 start = 1'b0;
    wait_idle();

    // Start in the DONE cycle: accepted on the same edge that publishes the previous result.
    send(16'd999);
    chk_eq("b2b_done", 0, 32'(done_v[0]), 32'd1);
    chk_eq("b2b_busy", 0, 32'(busy_v[0]), 32'd1);
    chk_eq("b2b_done", 1, 32'(done_v[1]), 32'd1);
    chk_eq("b2b_busy", 1, 32'(busy_v[1]), 32'd1);
    wait_idle();
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-conversion aborts without a done.
    send(16'd1234);
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'd45);
    wait_idle();
    repeat (4) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      chk_eq("drain", i, 32'(sb[i].size()), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
